can_traffic_gen: RTL
====================

Name: can_traffic_gen

Overview:
Parametrised periodic CAN traffic generator and receive monitor driving can_simple_top's transmit request interface (id/data/strobe/succeed/failed) and observing its receive outputs. It round-robins over NUM_IDS identifiers and supports three payload patterns. It retries failed frames, times out hung transmissions and keeps saturating statistics counters. Replaces hand-written per-board test wrappers.

Parameters:
PERIOD_CYCLES, 500000, clock cycles between frame-start ticks (>=2)
NUM_IDS, 4, identifiers in rotation (1..16)
ID_BASE, 11'h350, first identifier; channel k uses ID_BASE+k (mod 2^11)
MAX_RETRY, 2, retransmissions after a failed attempt before the frame is dropped
TIMEOUT_CYCLES, 100000, WAIT cycles without a result before the attempt counts as failed

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
enable_i  in  1  enables tick generation and new frame starts
mode_i  in  2  payload: 0 counter, 1 ramp, 2 LFSR, 3 same as 0
tx_id_o  out  11  identifier to CAN core
tx_data_o  out  64  payload to CAN core
tx_start_strobe_o  out  1  one-cycle transmit request
tx_succeed_i  in  1  one-cycle success pulse from core
tx_failed_i  in  1  one-cycle failure pulse from core
rx_data_i  in  80  received frame from core
rx_dvalid_i  in  1  one-cycle receive valid
busy_o  out  1  FSM not in IDLE
fail_flag_o  out  1  sticky; set on dropped frame, cleared on next success
tx_ok_cnt_o  out  16  successful frames
tx_fail_cnt_o  out  16  failed attempts (incl. timeouts)
drop_cnt_o  out  16  frames dropped after retries exhausted
missed_cnt_o  out  16  ticks lost while a tick was already pending
rx_cnt_o  out  16  received frames
rx_last_byte_o  out  8  rx_data_i[7:0] of last received frame

Behaviour:
- Reset: all counters/flags/outputs 0, tx_id_o=ID_BASE, tx_data_o=0, seq=0, ch=0, lfsr=16'hACE1, FSM=IDLE, period counter 0, pending=0.
- Period counter: while enable_i, counts 0..PERIOD_CYCLES-1 and wraps; tick in wrap cycle. While !enable_i held at 0, pending cleared. First tick PERIOD_CYCLES cycles after enable rises.
- Tick sets pending; if pending already set and not consumed that cycle, missed_cnt_o increments.
- FSM states: IDLE, LOAD, START, WAIT.
- IDLE: pending && enable_i -> LOAD, clear pending.
- LOAD (1 cycle): register tx_id_o=ID_BASE+ch; tx_data_o per mode_i sampled here: mode0 {8{seq[7:0]}}; mode1 byte i ([8i+7:8i]) = seq[7:0]+i mod 256; mode2 {4{lfsr}}. retry_cnt=0 on first attempt. -> START.
- START (1 cycle): tx_start_strobe_o=1 (registered, exactly one cycle). Timeout counter cleared. -> WAIT.
- WAIT: tx_succeed_i (wins if simultaneous with failed) -> tx_ok_cnt++, fail_flag_o=0, advance, IDLE. tx_failed_i or timeout counter reaching TIMEOUT_CYCLES-1 -> tx_fail_cnt++; if retry_cnt<MAX_RETRY: retry_cnt++, -> START (same id/data); else drop_cnt++, fail_flag_o=1, advance, IDLE.
- Result pulses outside WAIT ignored.
- Advance: seq+=1 (16-bit wrap), ch=(ch==NUM_IDS-1)?0:ch+1, lfsr steps once (Galois, taps x^16+x^14+x^13+x^11+1).
- tx_id_o/tx_data_o stable from LOAD until next LOAD.
- enable_i deasserted mid-frame: current frame runs to completion incl. retries; no new LOAD.
- Rx monitor independent of FSM: rx_dvalid_i -> rx_cnt++, rx_last_byte_o=rx_data_i[7:0], next cycle.
- All 16-bit counters saturate at 16'hFFFF.
- Reset asserted mid-operation: immediate return to reset state, strobe drops asynchronously.

Test Plan:
- PERIOD_CYCLES=100, mode0, core replies succeed 20 cycles after each strobe -> strobes at cycles 102, 202, ...; data 64'h0000..., 64'h0101..., ids 350,351,352,353,350; tx_ok_cnt=5 after 5 frames.
- mode1 seq=3 -> tx_data_o=64'h0A09080706050403; mode2 first frame -> 64'hACE1ACE1ACE1ACE1.
- Core always fails -> 3 strobes per frame, tx_fail_cnt+=3, drop_cnt=1, fail_flag_o=1, id advances; next success clears flag.
- No reply, TIMEOUT_CYCLES=50 -> failure recorded 50 cycles after strobe, retry strobe follows; succeed+failed same cycle -> counted success.
- Core holds WAIT 250 cycles with PERIOD_CYCLES=100 -> missed_cnt=1, exactly one frame launched after WAIT exits.
- rx_dvalid_i with rx_data_i[7:0]=8'h5A -> rx_cnt=1, rx_last_byte_o=8'h5A; rst_i pulsed during WAIT -> all outputs to reset values, strobe low.

Source files
------------

// File: rtl/can_traffic_gen_if.sv
// Transmit-request / receive bundle between the traffic generator and the CAN core.
//   master : generator side (drives id/data/strobe, observes result pulses and rx)
//   slave  : CAN core side
// Signal names keep the generator-relative _o/_i suffixes so existing board
// wrappers map one-to-one onto the bundle.
interface can_traffic_gen_if;
  logic [10:0] tx_id_o;
  logic [63:0] tx_data_o;
  logic        tx_start_strobe_o;
  logic        tx_succeed_i;
  logic        tx_failed_i;
  logic [79:0] rx_data_i;
  logic        rx_dvalid_i;

  modport master (
    output tx_id_o, tx_data_o, tx_start_strobe_o,
    input  tx_succeed_i, tx_failed_i, rx_data_i, rx_dvalid_i
  );

  modport slave (
    input  tx_id_o, tx_data_o, tx_start_strobe_o,
    output tx_succeed_i, tx_failed_i, rx_data_i, rx_dvalid_i
  );
endinterface

// File: rtl/can_traffic_gen.sv
// Periodic CAN traffic generator with retry/timeout handling and a receive monitor.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   enable_i          enables tick generation and new frame starts
//   mode_i            payload pattern: 0/3 counter, 1 ramp, 2 LFSR
//   can_if (master)   tx id/data/strobe to the core, result pulses and rx from it
//   busy_o            FSM not idle
//   fail_flag_o       sticky drop indication, cleared by the next success
//   tx_ok_cnt_o, tx_fail_cnt_o, drop_cnt_o, missed_cnt_o, rx_cnt_o
//                     saturating 16-bit statistics
//   rx_last_byte_o    low byte of the most recent received frame
module can_traffic_gen #(
  parameter int unsigned PERIOD_CYCLES  = 500000,
  parameter int unsigned NUM_IDS        = 4,
  parameter logic [10:0] ID_BASE        = 11'h350,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [1:0]          mode_i,
  can_traffic_gen_if.master   can_if,
  output logic                busy_o,
  output logic                fail_flag_o,
  output logic [15:0]         tx_ok_cnt_o,
  output logic [15:0]         tx_fail_cnt_o,
  output logic [15:0]         drop_cnt_o,
  output logic [15:0]         missed_cnt_o,
  output logic [15:0]         rx_cnt_o,
  output logic [7:0]          rx_last_byte_o
);

  localparam int unsigned PER_W = (PERIOD_CYCLES  > 2) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int unsigned CH_W  = (NUM_IDS        > 2) ? $clog2(NUM_IDS)        : 1;
  localparam int unsigned RT_W  = (MAX_RETRY      > 1) ? $clog2(MAX_RETRY + 1)  : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;

  state_e             state_q, state_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic               pending_q, pending_d;
  logic [15:0]        seq_q, seq_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [RT_W-1:0]    retry_q, retry_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [10:0]        id_q, id_d;
  logic [63:0]        data_q, data_d;
  logic               strobe_q, strobe_d;
  logic               fail_flag_q, fail_flag_d;
  logic [15:0]        ok_q, ok_d;
  logic [15:0]        fail_q, fail_d;
  logic [15:0]        drop_q, drop_d;
  logic [15:0]        missed_q, missed_d;
  logic [15:0]        rx_cnt_q, rx_cnt_d;
  logic [7:0]         rx_last_q, rx_last_d;

  logic tick, consume, advance, timeout;
  logic unused_rx;

  assign unused_rx = ^can_if.rx_data_i[79:8];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    pending_d   = pending_q;
    seq_d       = seq_q;
    ch_d        = ch_q;
    lfsr_d      = lfsr_q;
    retry_d     = retry_q;
    to_cnt_d    = to_cnt_q;
    id_d        = id_q;
    data_d      = data_q;
    fail_flag_d = fail_flag_q;
    ok_d        = ok_q;
    fail_d      = fail_q;
    drop_d      = drop_q;
    missed_d    = missed_q;
    rx_cnt_d    = rx_cnt_q;
    rx_last_d   = rx_last_q;
    advance     = 1'b0;

    tick    = enable_i && (per_cnt_q == PER_W'(PERIOD_CYCLES - 1));
    consume = (state_q == IDLE) && pending_q && enable_i;
    timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    if (!enable_i)  per_cnt_d = '0;
    else if (tick)  per_cnt_d = '0;
    else            per_cnt_d = per_cnt_q + PER_W'(1);

    // A tick arriving in the same cycle the previous one is consumed re-arms
    // pending without counting as missed.
    if (consume) pending_d = 1'b0;
    if (tick) begin
      if (pending_q && !consume) missed_d = sat_inc(missed_q);
      pending_d = 1'b1;
    end
    if (!enable_i) pending_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (consume) state_d = LOAD;
      end
      LOAD: begin
        id_d = ID_BASE + 11'(ch_q);
        case (mode_i)
          2'd1: begin
            for (int unsigned i = 0; i < 8; i++) data_d[8*i +: 8] = seq_q[7:0] + 8'(i);
          end
          2'd2:    data_d = {4{lfsr_q}};
          default: data_d = {8{seq_q[7:0]}};
        endcase
        retry_d = '0;
        state_d = START;
      end
      START: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (can_if.tx_succeed_i) begin
          ok_d        = sat_inc(ok_q);
          fail_flag_d = 1'b0;
          advance     = 1'b1;
          state_d     = IDLE;
        end else if (can_if.tx_failed_i || timeout) begin
          fail_d = sat_inc(fail_q);
          if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d = retry_q + RT_W'(1);
            state_d = START;
          end else begin
            drop_d      = sat_inc(drop_q);
            fail_flag_d = 1'b1;
            advance     = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      seq_d  = seq_q + 16'd1;
      ch_d   = (ch_q == CH_W'(NUM_IDS - 1)) ? '0 : ch_q + CH_W'(1);
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Registered strobe: high exactly for the cycle spent in START.
    strobe_d = (state_d == START);

    if (can_if.rx_dvalid_i) begin
      rx_cnt_d  = sat_inc(rx_cnt_q);
      rx_last_d = can_if.rx_data_i[7:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      pending_q   <= 1'b0;
      seq_q       <= '0;
      ch_q        <= '0;
      lfsr_q      <= 16'hACE1;
      retry_q     <= '0;
      to_cnt_q    <= '0;
      id_q        <= ID_BASE;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      fail_flag_q <= 1'b0;
      ok_q        <= '0;
      fail_q      <= '0;
      drop_q      <= '0;
      missed_q    <= '0;
      rx_cnt_q    <= '0;
      rx_last_q   <= '0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      pending_q   <= pending_d;
      seq_q       <= seq_d;
      ch_q        <= ch_d;
      lfsr_q      <= lfsr_d;
      retry_q     <= retry_d;
      to_cnt_q    <= to_cnt_d;
      id_q        <= id_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      fail_flag_q <= fail_flag_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      drop_q      <= drop_d;
      missed_q    <= missed_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_last_q   <= rx_last_d;
    end
  end

  assign can_if.tx_id_o           = id_q;
  assign can_if.tx_data_o         = data_q;
  assign can_if.tx_start_strobe_o = strobe_q;
  assign busy_o                   = (state_q != IDLE);
  assign fail_flag_o              = fail_flag_q;
  assign tx_ok_cnt_o              = ok_q;
  assign tx_fail_cnt_o            = fail_q;
  assign drop_cnt_o               = drop_q;
  assign missed_cnt_o             = missed_q;
  assign rx_cnt_o                 = rx_cnt_q;
  assign rx_last_byte_o           = rx_last_q;

endmodule
